// File: rtl/arb_types.sv
// Shared types for the instruction/data memory arbiter.
package arb_types;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: multiplexes the I-side and D-side line fill and
// writeback handshakes onto one physical memory port. One transaction is
// in flight at a time; contention is settled round-robin.
module mem_arbiter
  import arb_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        r_state;
  grant_t            r_last_grant;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [LINE_W-1:0] r_cmd_wdata;
  logic              r_cmd_is_write;

  logic   w_i_req;
  logic   w_d_req;
  grant_t w_pick;

  // Round-robin pick: on contention the side not served last wins.
  always_comb begin
    w_i_req = i_read;
    w_d_req = d_read | d_write;
    w_pick  = GRANT_I;
    if (w_i_req && w_d_req) begin
      w_pick = (r_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (w_d_req) begin
      w_pick = GRANT_D;
    end
  end

  // Transaction FSM: latch the granted command in IDLE, hold it until memory completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_last_grant   <= GRANT_I;
      r_cmd_addr     <= '0;
      r_cmd_wdata    <= '0;
      r_cmd_is_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_i_req || w_d_req) begin
            if (w_pick == GRANT_D) begin
              r_state        <= SERVE_D;
              r_cmd_addr     <= d_addr;
              r_cmd_wdata    <= d_wdata;
              r_cmd_is_write <= d_write;
            end else begin
              r_state        <= SERVE_I;
              r_cmd_addr     <= i_addr;
              r_cmd_is_write <= 1'b0;
            end
          end
        end
        SERVE_I: begin
          if (pmem_resp) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_I;
          end
        end
        SERVE_D: begin
          if (pmem_resp) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_D;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory command is a pure function of the state and the latched command,
  // so it stays stable for the whole transaction regardless of client inputs.
  assign pmem_read  = (r_state == SERVE_I) || ((r_state == SERVE_D) && !r_cmd_is_write);
  assign pmem_write = (r_state == SERVE_D) && r_cmd_is_write;
  assign pmem_addr  = r_cmd_addr;
  assign pmem_wdata = r_cmd_wdata;

  // Completion is steered to the side being served; a response seen in IDLE
  // (stray or left over from an aborted transaction) reaches neither side.
  assign i_resp  = (r_state == SERVE_I) && pmem_resp;
  assign d_resp  = (r_state == SERVE_D) && pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int checks;
  int errors;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
  endtask

  task automatic apply_reset();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    pmem_resp = 1;
    pmem_rdata = {8{32'hDEADBEEF}};
    tick();
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
    checks++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      errors++; $display("FAIL reset_rdata got i=%h d=%h exp 0", i_rdata, d_rdata);
    end
    checks++;
    if (pmem_addr !== '0 || pmem_wdata !== '0) begin
      errors++; $display("FAIL reset_latch got addr=%h wdata=%h exp 0", pmem_addr, pmem_wdata);
    end
    pmem_resp = 0;
    rst = 1;
  endtask

  task automatic test_i_read();
    idle_inputs();
    i_read = 1; i_addr = 32'h0000_0060;
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++; $display("FAIL i_grant_latency got %b exp 0", pmem_read);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) begin
        pmem_resp = 1; pmem_rdata = {8{32'hA5A5A5A5}};
      end
      #1;
      checks++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_addr !== 32'h60) begin
        errors++; $display("FAIL i_cmd c%0d got rd=%b wr=%b addr=%h exp 1 0 60", c, pmem_read, pmem_write, pmem_addr);
      end
    end
    checks++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== {8{32'hA5A5A5A5}}) begin
      errors++; $display("FAIL i_resp got i=%b d=%b rdata=%h exp 1 0 a5..", i_resp, d_resp, i_rdata);
    end
    tick();
    pmem_resp = 0; i_read = 0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || i_resp !== 1'b0 || i_rdata !== '0) begin
      errors++; $display("FAIL i_done got rd=%b resp=%b rdata=%h exp 0 0 0", pmem_read, i_resp, i_rdata);
    end
  endtask

  task automatic test_d_write();
    logic [LINE_W-1:0] wd;
    logic [LINE_W-1:0] rd;
    wd = {8{32'h12345678}};
    rd = rand_line();
    idle_inputs();
    d_write = 1; d_read = 1; d_addr = 32'h0000_1000; d_wdata = wd;
    tick();
    #1;
    checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 32'h1000 || pmem_wdata !== wd) begin
      errors++; $display("FAIL d_write_cmd got wr=%b rd=%b addr=%h wdata=%h", pmem_write, pmem_read, pmem_addr, pmem_wdata);
    end
    tick();
    pmem_resp = 1; pmem_rdata = rd;
    #1;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== rd || i_rdata !== '0) begin
      errors++; $display("FAIL d_write_resp got d=%b i=%b d_rdata=%h exp d=1 i=0 %h", d_resp, i_resp, d_rdata, rd);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (pmem_write !== 1'b0 || d_resp !== 1'b0) begin
      errors++; $display("FAIL d_write_done got wr=%b resp=%b exp 0 0", pmem_write, d_resp);
    end
  endtask

  task automatic test_contention();
    logic exp_d;
    apply_reset();
    idle_inputs();
    i_read = 1; i_addr = 32'h0000_0400;
    d_read = 1; d_addr = 32'h0000_0800;
    exp_d = 1;
    for (int g = 0; g < 4; g++) begin
      #1;
      checks++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
        errors++; $display("FAIL contend_idle g%0d got rd=%b wr=%b exp 0 0", g, pmem_read, pmem_write);
      end
      tick();
      pmem_resp = 1; pmem_rdata = rand_line();
      #1;
      checks++;
      if (pmem_read !== 1'b1 || pmem_addr !== (exp_d ? 32'h800 : 32'h400) ||
          d_resp !== exp_d || i_resp !== !exp_d) begin
        errors++; $display("FAIL contend_grant g%0d got addr=%h d=%b i=%b exp_d=%b", g, pmem_addr, d_resp, i_resp, exp_d);
      end
      tick();
      pmem_resp = 0;
      exp_d = !exp_d;
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_drop();
    idle_inputs();
    d_read = 1; d_addr = 32'h0000_3000;
    tick();
    d_read = 0; d_addr = 32'h0000_2000;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        pmem_resp = 1; pmem_rdata = {8{32'h0BADF00D}};
      end
      #1;
      checks++;
      if (pmem_read !== 1'b1 || pmem_addr !== 32'h3000) begin
        errors++; $display("FAIL drop_hold c%0d got rd=%b addr=%h exp 1 3000", c, pmem_read, pmem_addr);
      end
      if (c < 3) tick();
    end
    checks++;
    if (d_resp !== 1'b1 || d_rdata !== {8{32'h0BADF00D}}) begin
      errors++; $display("FAIL drop_resp got resp=%b rdata=%h exp 1 0badf00d..", d_resp, d_rdata);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++; $display("FAIL drop_done got rd=%b exp 0", pmem_read);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    i_read = 1; i_addr = 32'h0000_0080;
    tick();
    #1;
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++; $display("FAIL rmid_serve got rd=%b exp 1", pmem_read);
    end
    rst = 0; i_read = 0;
    tick();
    rst = 1;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      errors++; $display("FAIL rmid_abort got rd=%b wr=%b exp 0 0", pmem_read, pmem_write);
    end
    tick();
    pmem_resp = 1; pmem_rdata = rand_line();
    #1;
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== '0) begin
      errors++; $display("FAIL rmid_stale got i=%b d=%b exp 0 0", i_resp, d_resp);
    end
    tick();
    pmem_resp = 0;
  endtask

  task automatic test_stray();
    idle_inputs();
    pmem_resp = 1; pmem_rdata = rand_line();
    #1;
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || d_rdata !== '0) begin
      errors++; $display("FAIL stray_resp got i=%b d=%b exp 0 0", i_resp, d_resp);
    end
    tick();
    pmem_resp = 0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      errors++; $display("FAIL stray_state got rd=%b wr=%b exp 0 0", pmem_read, pmem_write);
    end
  endtask

  // Randomized traffic. The model tracks the in-flight transaction as a
  // record (owner, address, data, direction) plus who was served last.
  task automatic test_random();
    bit                m_busy;
    bit                m_side_d;
    bit                m_last_d;
    bit                m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    bit                e_rd, e_wr, e_ir, e_dr;
    bit                prev_ir, prev_dr;
    bit                ireq, dreq, pick_d;

    apply_reset();
    idle_inputs();
    m_busy = 0; m_last_d = 0; m_side_d = 0; m_wr = 0;
    m_addr = '0; m_wdata = '0;
    prev_ir = 0; prev_dr = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      // clients: drop after completion, otherwise maybe raise a new request
      if (prev_ir) i_read = 0;
      else if (!i_read && ($urandom_range(0, 2) == 0)) begin
        i_read = 1; i_addr = {$urandom} & 32'hFFFF_FFE0;
      end
      if (prev_dr) begin
        d_read = 0; d_write = 0;
      end else if (!d_read && !d_write && ($urandom_range(0, 2) == 0)) begin
        d_addr = {$urandom} & 32'hFFFF_FFE0;
        d_wdata = rand_line();
        case ($urandom_range(0, 2))
          0: begin d_read = 1; d_write = 0; end
          1: begin d_read = 0; d_write = 1; end
          default: begin d_read = 1; d_write = 1; end
        endcase
      end
      pmem_resp  = ($urandom_range(0, 2) == 0);
      pmem_rdata = rand_line();
      rst        = ($urandom_range(0, 63) != 0);
      #1;

      e_rd = m_busy && !(m_side_d && m_wr);
      e_wr = m_busy && m_side_d && m_wr;
      e_ir = m_busy && !m_side_d && pmem_resp;
      e_dr = m_busy && m_side_d && pmem_resp;

      checks++;
      if (pmem_read !== e_rd || pmem_write !== e_wr) begin
        errors++; $display("FAIL rnd_cmd cyc%0d got rd=%b wr=%b exp %b %b", cyc, pmem_read, pmem_write, e_rd, e_wr);
      end
      checks++;
      if (i_resp !== e_ir || d_resp !== e_dr) begin
        errors++; $display("FAIL rnd_resp cyc%0d got i=%b d=%b exp %b %b", cyc, i_resp, d_resp, e_ir, e_dr);
      end
      checks++;
      if (i_rdata !== (e_ir ? pmem_rdata : '0) || d_rdata !== (e_dr ? pmem_rdata : '0)) begin
        errors++; $display("FAIL rnd_rdata cyc%0d got i=%h d=%h", cyc, i_rdata, d_rdata);
      end
      if (m_busy) begin
        checks++;
        if (pmem_addr !== m_addr || (m_wr && pmem_wdata !== m_wdata)) begin
          errors++; $display("FAIL rnd_latch cyc%0d got addr=%h exp %h", cyc, pmem_addr, m_addr);
        end
      end

      // advance the model across the coming edge
      prev_ir = e_ir && rst;
      prev_dr = e_dr && rst;
      if (!rst) begin
        m_busy = 0; m_last_d = 0; m_addr = '0; m_wdata = '0; m_wr = 0;
      end else if (m_busy) begin
        if (pmem_resp) begin
          m_busy = 0; m_last_d = m_side_d;
        end
      end else begin
        ireq = i_read;
        dreq = d_read || d_write;
        if (ireq || dreq) begin
          pick_d = (ireq && dreq) ? !m_last_d : dreq;
          m_busy = 1; m_side_d = pick_d;
          if (pick_d) begin
            m_addr = d_addr; m_wdata = d_wdata; m_wr = d_write;
          end else begin
            m_addr = i_addr; m_wr = 0;
          end
        end
      end
      tick();
    end
    rst = 1;
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 0;
    idle_inputs();
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_drop();
    test_reset_mid();
    test_stray();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
